// File: rtl/fetch_unit.sv
// Instruction fetch unit: FETCH/EXEC/ERROR FSM that requests a word, holds it for downstream
// and computes the next PC (sequential, taken branch, jump). A missing ack latches a terminal fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        advance,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic [31:0] branch_imm,
  input  logic [25:0] jump_target,
  output logic        fault,
  output logic [15:0] retired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   pc_out_q, pc_out_d;
  logic          valid_q, valid_d;
  logic          fault_q, fault_d;
  logic [15:0]   retired_q, retired_d;
  logic [CW-1:0] wait_q, wait_d;

  logic [31:0]   pc4;
  logic [31:0]   next_pc;

  // Next PC is relative to the latched instruction; jump beats branch.
  always_comb begin
    pc4     = pc_out_q + 32'd4;
    next_pc = pc4;
    if (jump) begin
      next_pc = {pc4[31:28], jump_target, 2'b00};
    end else if (branch && zero) begin
      next_pc = pc4 + (branch_imm << 2);
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pc_out_d  = pc_out_q;
    valid_d   = valid_q;
    fault_d   = fault_q;
    retired_d = retired_q;
    wait_d    = wait_q;
    case (state_q)
      S_FETCH: begin
        // An ack on the last allowed cycle still counts as a normal fetch.
        if (imem_ack) begin
          instr_d  = imem_rdata;
          pc_out_d = pc_q;
          wait_d   = '0;
          valid_d  = 1'b1;
          state_d  = S_EXEC;
        end else if (wait_q == WAIT_LAST) begin
          fault_d  = 1'b1;
          valid_d  = 1'b0;
          state_d  = S_ERROR;
        end else begin
          wait_d   = wait_q + CW'(1);
        end
      end
      S_EXEC: begin
        if (advance) begin
          pc_d      = next_pc;
          valid_d   = 1'b0;
          retired_d = retired_q + 16'd1;
          state_d   = S_FETCH;
        end
      end
      S_ERROR: begin
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      pc_out_q  <= '0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      retired_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc_out_q  <= pc_out_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
      wait_q    <= wait_d;
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;
  assign fault       = fault_q;
  assign retired     = retired_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded by reset.
REQ-002 Parameter TIMEOUT, default 15, SHALL be the maximum number of FETCH cycles without imem_ack before fault.
REQ-003 Ports SHALL be:
 clk  in  1  single clock, rising edge
 reset  in  1  synchronous, active-high
 imem_req  out  1  instruction memory request
 imem_addr  out  32  fetch address (always equals pc)
 imem_ack  in  1  memory returns data this cycle
 imem_rdata  in  32  instruction word, valid when imem_ack=1
 instr  out  32  latched instruction
 opcode  out  6  instr[31:26], drives the control unit's opcode input
 pc_out  out  32  PC of the latched instruction
 instr_valid  out  1  instr/opcode/pc_out valid
 advance  in  1  downstream done with current instruction; pulse
 branch  in  1  control unit branch output
 zero  in  1  ALU zero flag
 jump  in  1  control unit jump output
 branch_imm  in  32  sign-extended 16-bit immediate
 jump_target  in  26  instr[25:0] field
 fault  out  1  sticky memory-timeout flag
 retired  out  16  count of accepted advances

Function
REQ-004 FSM states SHALL be FETCH, EXEC, ERROR, with a registered state.
REQ-005 imem_req SHALL be 1 iff state==FETCH; imem_addr SHALL equal pc in every cycle.
REQ-006 In FETCH with imem_ack=1: instr<=imem_rdata, pc_out<=pc, wait counter<=0, state<=EXEC; instr_valid SHALL be 1 from the next cycle (fetch latency 1 cycle after ack).
REQ-007 In FETCH with imem_ack=0: wait counter increments; when the counter equals TIMEOUT-1 in that cycle, state<=ERROR and fault<=1.
REQ-008 imem_ack in the same cycle the counter reaches TIMEOUT-1 SHALL win: normal transition to EXEC, no fault.
REQ-009 In EXEC: instr_valid=1, opcode=instr[31:26]; state holds until advance=1.
REQ-010 On advance in EXEC, pc SHALL update using inputs sampled that cycle, with pc4=pc_out+4:
 jump=1 -> {pc4[31:28], jump_target, 2'b00}
 else branch=1 and zero=1 -> pc4 + (branch_imm<<2)
 else -> pc4.
REQ-011 jump SHALL take priority over branch when both are 1.
REQ-012 All PC arithmetic SHALL be 32-bit modulo 2^32 (32'hFFFF_FFFC+4 -> 32'h0000_0000).
REQ-013 On advance in EXEC: state<=FETCH, instr_valid<=0 next cycle, retired<=retired+1 (16-bit wrap 16'hFFFF -> 16'h0000).
REQ-014 advance outside EXEC SHALL be ignored (no PC, retired, or state change).
REQ-015 imem_ack outside FETCH SHALL be ignored; instr SHALL not change.
REQ-016 ERROR SHALL be terminal: imem_req=0, instr_valid=0, fault=1 until reset.
REQ-017 Minimum throughput SHALL be one instruction per 2 cycles (ack in the first FETCH cycle, advance in the first EXEC cycle).

Reset
REQ-018 While reset=1 at a clock edge: pc<=RESET_PC, state<=FETCH, instr<=0, pc_out<=0, instr_valid<=0, fault<=0, retired<=0, wait counter<=0.
REQ-019 Reset SHALL override all inputs, including imem_ack and advance in the same cycle; reset mid-FETCH or mid-EXEC discards the instruction in flight.
REQ-020 In the first cycle after reset deasserts: imem_req=1 and imem_addr=RESET_PC.

Verification
REQ-021 Sequential: ack at 0x0 with rdata=32'h8C22_0004, advance with branch=jump=0 -> opcode=6'b100011, pc_out=0, next imem_addr=0x4, retired=1.
REQ-022 Taken branch: pc_out=0x10, branch=1, zero=1, branch_imm=32'hFFFF_FFFE -> next imem_addr=0x0C; with zero=0 -> 0x14.
REQ-023 Jump precedence: pc_out=0x1000_0040, jump=1, branch=1, zero=1, jump_target=26'h000_0010 -> next imem_addr=0x1000_0040.
REQ-024 Timeout: hold imem_ack=0 for 15 FETCH cycles -> fault=1, imem_req=0 thereafter; repeat with ack on the 15th cycle -> EXEC, fault=0.
REQ-025 Reset mid-operation: reset in EXEC with advance=1 -> pc=RESET_PC, retired=0, instr_valid=0, imem_req=1 in the next cycle.
REQ-026 Wrap: pc_out=32'hFFFF_FFFC, advance -> imem_addr=0; 65536 advances -> retired=0.
